// File: rtl/pipe_result_credit_buffer_if.sv
// Result-path bundle of the credit buffer: upstream argument handshake, datapath issue/return
// and the downstream result stream. The buffer uses the master modport, its environment uses slave.
interface pipe_result_credit_buffer_if #(
   parameter int FLEN = 64
);
   // Handshake rule: a transfer happens on a rising edge where vld & rdy are both 1; a source
   // never withdraws vld or changes its data before the transfer; rdy may depend only on
   // registered state. pipe_res_vld is a one-cycle pulse with no ready (the datapath cannot stall).
   logic            arg_vld;
   logic            arg_rdy;
   logic            pipe_issue;
   logic            pipe_res_vld;
   logic [FLEN-1:0] pipe_res;
   logic            res_vld;
   logic            res_rdy;
   logic [FLEN-1:0] res;
   logic            overflow;

   modport master (
      input  arg_vld, pipe_res_vld, pipe_res, res_rdy,
      output arg_rdy, pipe_issue, res_vld, res, overflow
   );

   modport slave (
      output arg_vld, pipe_res_vld, pipe_res, res_rdy,
      input  arg_rdy, pipe_issue, res_vld, res, overflow
   );
endinterface

// File: rtl/pipe_result_credit_buffer.sv
// Result FIFO for a non-stallable fixed-latency datapath. Upstream issue is credit-gated so
// every result in flight owns a FIFO slot; results leave through a valid/ready stream.
module pipe_result_credit_buffer #(
   parameter int FLEN    = 64,
   parameter int DEPTH   = 16,
   parameter int LATENCY = 8
) (
   input logic                          clk,
   input logic                          rst,
   pipe_result_credit_buffer_if.master  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   if (DEPTH < LATENCY + 1) begin : g_depth_too_small
      $error("pipe_result_credit_buffer: DEPTH must be at least LATENCY+1");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_not_pow2
      $error("pipe_result_credit_buffer: DEPTH must be a power of 2 and >= 2");
   end

   logic [FLEN-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   fill;      // entries held in the FIFO
   logic [CW-1:0]   used;      // credits consumed: in flight plus FIFO occupancy
   logic            overflow_q;

   logic full;
   logic empty;
   logic credit_ok;
   logic issue;
   logic pop;
   logic wr;
   logic drop;

   assign full      = (fill == CW'(DEPTH));
   assign empty     = (fill == '0);
   assign credit_ok = (used != CW'(DEPTH));
   assign issue     = bus.arg_vld & credit_ok;
   assign pop       = ~empty & bus.res_rdy;
   // A pop frees the head slot in the same cycle, so a full FIFO still accepts a return then.
   assign wr        = bus.pipe_res_vld & (~full | pop);
   assign drop      = bus.pipe_res_vld & full & ~pop;

   assign bus.arg_rdy    = credit_ok;
   assign bus.pipe_issue = issue;
   assign bus.res_vld    = ~empty;
   assign bus.res        = empty ? '0 : mem[rd_ptr];
   assign bus.overflow   = overflow_q;

   always_ff @(posedge clk) begin
      if (!rst && wr) begin
         mem[wr_ptr] <= bus.pipe_res;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill       <= '0;
         used       <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         unique case ({wr, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase

         unique case ({issue, pop})
            2'b10:   used <= used + 1'b1;
            2'b01:   used <= used - 1'b1;
            default: used <= used;
         endcase

         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pipe_result_credit_buffer.sv
// Bench for pipe_result_credit_buffer: fixed-delay datapath model, credit/ordering reference
// model with an expected-value queue, and directed plus random stream phases.
module tb_pipe_result_credit_buffer;
   localparam int FLEN    = 64;
   localparam int DEPTH   = 16;
   localparam int LATENCY = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_result_credit_buffer_if #(.FLEN(FLEN)) bus ();

   pipe_result_credit_buffer #(
      .FLEN    (FLEN),
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // scoreboard and reference model state
   logic [FLEN-1:0] exp_q[$];
   int              n_checks = 0;
   int              n_pass   = 0;
   int              m_used   = 0;
   bit              m_ovf    = 1'b0;
   int              n_issued = 0;
   int              cyc      = 0;
   int              rdy_low  = 0;
   bit              track_lat = 1'b0;
   int              first_iss = -1;
   int              first_vld = -1;
   bit              hold_prev = 1'b0;
   logic [FLEN-1:0] hold_res  = '0;

   // datapath delay line and error injection
   bit              dl_v [LATENCY];
   logic [FLEN-1:0] dl_d [LATENCY];
   bit              inj_v      = 1'b0;
   bit              inj_accept = 1'b0;
   logic [FLEN-1:0] inj_d      = '0;

   assign bus.pipe_res_vld = dl_v[LATENCY-1] | inj_v;
   assign bus.pipe_res     = inj_v ? inj_d : dl_d[LATENCY-1];

   task automatic check(input string name, input logic [FLEN-1:0] act, input logic [FLEN-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic inject(input bit accept);
      inj_d      = {$urandom(), $urandom()};
      inj_accept = accept;
      inj_v      = 1'b1;
      tick(1);
      inj_v      = 1'b0;
   endtask

   task automatic drain(input int bound, input bit rnd);
      int k = 0;
      while (exp_q.size() != 0 && k < bound) begin
         bus.res_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick(1);
         k++;
      end
      bus.res_rdy = 1'b0;
      check("drain_empty", FLEN'(exp_q.size()), '0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_arg_rdy"},  FLEN'(bus.arg_rdy),  FLEN'(1));
      check({tag, "_res_vld"},  FLEN'(bus.res_vld),  '0);
      check({tag, "_overflow"}, FLEN'(bus.overflow), '0);
      check({tag, "_res"},      bus.res,             '0);
   endtask

   // Monitor + reference model: checks at the falling edge, then predicts the next rising edge.
   initial begin
      bit              nv [LATENCY];
      logic [FLEN-1:0] nd [LATENCY];
      logic [FLEN-1:0] v;
      logic [FLEN-1:0] e;
      bit              iss;
      bit              pop;
      forever begin
         @(negedge clk);
         cyc++;
         check("arg_rdy_credit", FLEN'(bus.arg_rdy), FLEN'(m_used != DEPTH));
         check("pipe_issue", FLEN'(bus.pipe_issue), FLEN'(bus.arg_vld && (m_used != DEPTH)));
         check("overflow_state", FLEN'(bus.overflow), FLEN'(m_ovf));
         if (hold_prev) begin
            check("hold_vld", FLEN'(bus.res_vld), FLEN'(1));
            check("hold_res", bus.res, hold_res);
         end
         if (!bus.arg_rdy) rdy_low++;
         if (!rst && bus.res_vld && track_lat && first_vld < 0) first_vld = cyc;
         pop = !rst && bus.res_vld && bus.res_rdy;
         if (pop) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_output: got %h expected no output", bus.res);
            end else begin
               e = exp_q.pop_front();
               check("res_data", bus.res, e);
            end
         end
         hold_prev = !rst && bus.res_vld && !bus.res_rdy;
         hold_res  = bus.res;

         for (int i = LATENCY - 1; i > 0; i--) begin
            nv[i] = dl_v[i-1];
            nd[i] = dl_d[i-1];
         end
         if (rst) begin
            exp_q.delete();
            m_used = 0;
            m_ovf  = 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
               nv[i] = 1'b0;
               nd[i] = '0;
            end
         end else begin
            iss = bus.pipe_issue;
            v   = {$urandom(), $urandom()};
            if (iss) begin
               exp_q.push_back(v);
               n_issued++;
               if (track_lat && first_iss < 0) first_iss = cyc;
            end
            nv[0] = iss;
            nd[0] = v;
            m_used = m_used + int'(iss) - int'(pop);
            if (inj_v) begin
               if (inj_accept) exp_q.push_back(inj_d);
               else m_ovf = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < LATENCY; i++) begin
            dl_v[i] = nv[i];
            dl_d[i] = nd[i];
         end
      end
   end

   initial begin
      int              base;
      int              k;
      logic [FLEN-1:0] r;
      for (int i = 0; i < LATENCY; i++) begin
         dl_v[i] = 1'b0;
         dl_d[i] = '0;
      end
      bus.arg_vld = 1'b0;
      bus.res_rdy = 1'b0;

      // reset held for 3 cycles, then idle
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(2);
      check_reset_outputs("reset");

      // back-to-back stream with res_rdy held high
      track_lat = 1'b1; first_iss = -1; first_vld = -1; rdy_low = 0;
      base = n_issued;
      bus.res_rdy = 1'b1;
      bus.arg_vld = 1'b1;
      tick(100);
      bus.arg_vld = 1'b0;
      check("stream_rdy_low_cycles", FLEN'(rdy_low), '0);
      check("stream_issue_count", FLEN'(n_issued - base), FLEN'(100));
      drain(200, 1'b0);
      check("stream_latency", FLEN'(first_vld - first_iss), FLEN'(LATENCY + 1));
      track_lat = 1'b0;

      // backpressure: exactly DEPTH issues accepted
      base = n_issued;
      bus.res_rdy = 1'b0;
      bus.arg_vld = 1'b1;
      tick(30);
      bus.arg_vld = 1'b0;
      check("bp_issue_count", FLEN'(n_issued - base), FLEN'(DEPTH));
      check("bp_arg_rdy_low", FLEN'(bus.arg_rdy), '0);
      tick(LATENCY + 2);
      check("bp_still_low", FLEN'(bus.arg_rdy), '0);
      bus.res_rdy = 1'b1;
      tick(1);
      bus.res_rdy = 1'b0;
      check("bp_pop_raises_rdy", FLEN'(bus.arg_rdy), FLEN'(1));
      drain(100, 1'b0);

      // issue and pop together at used=15, then fill to the brim
      bus.arg_vld = 1'b1;
      tick(15);
      bus.arg_vld = 1'b0;
      tick(LATENCY + 2);
      bus.arg_vld = 1'b1;
      bus.res_rdy = 1'b1;
      tick(1);
      bus.arg_vld = 1'b0;
      bus.res_rdy = 1'b0;
      check("simul_arg_rdy", FLEN'(bus.arg_rdy), FLEN'(1));
      bus.arg_vld = 1'b1;
      tick(1);
      bus.arg_vld = 1'b0;
      check("simul_one_credit_left", FLEN'(bus.arg_rdy), '0);
      tick(LATENCY + 2);

      // full FIFO: return and pop in the same cycle
      bus.res_rdy = 1'b1;
      inject(1'b1);
      bus.res_rdy = 1'b0;
      check("full_wr_pop_no_ovf", FLEN'(bus.overflow), '0);
      bus.res_rdy = 1'b1;
      tick(3);
      bus.res_rdy = 1'b0;

      // error injection into a full FIFO with res_rdy low
      inject(1'b1);
      inject(1'b1);
      inject(1'b1);
      r = bus.res;
      inject(1'b0);
      check("ovf_set", FLEN'(bus.overflow), FLEN'(1));
      check("ovf_res_vld", FLEN'(bus.res_vld), FLEN'(1));
      check("ovf_res_unchanged", bus.res, r);
      tick(5);
      check("ovf_sticky", FLEN'(bus.overflow), FLEN'(1));
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_reset_outputs("ovf_rst");
      tick(2);

      // random traffic, 1000 transactions, 50% res_rdy
      base = n_issued;
      k = 0;
      while (n_issued - base < 1000 && k < 20000) begin
         bus.arg_vld = ($urandom_range(0, 99) < 70);
         bus.res_rdy = 1'($urandom_range(0, 1));
         tick(1);
         k++;
      end
      bus.arg_vld = 1'b0;
      check("rand_issue_count", FLEN'(n_issued - base), FLEN'(1000));
      drain(5000, 1'b1);
      check("rand_overflow", FLEN'(bus.overflow), '0);

      // reset in the middle of a stream
      repeat (40) begin
         bus.arg_vld = ($urandom_range(0, 99) < 70);
         bus.res_rdy = 1'($urandom_range(0, 1));
         tick(1);
      end
      bus.arg_vld = 1'b0;
      bus.res_rdy = 1'b0;
      rst = 1'b1;
      tick(1);
      check_reset_outputs("mid_rst");
      rst = 1'b0;
      tick(1);

      // first post-reset issue behaves as from power-up
      track_lat = 1'b1; first_iss = -1; first_vld = -1;
      bus.res_rdy = 1'b1;
      bus.arg_vld = 1'b1;
      tick(50);
      bus.arg_vld = 1'b0;
      drain(200, 1'b0);
      check("post_rst_latency", FLEN'(first_vld - first_iss), FLEN'(LATENCY + 1));
      check("post_rst_overflow", FLEN'(bus.overflow), '0);
      track_lat = 1'b0;

      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
